// File: rtl/mdu_if.sv
// Request/result bundle between control and the multiply/divide unit.
// Control drives the request side; the unit returns busy/stall and HI/LO.
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, rs_val, rt_val,
    input  busy, stall_req, hi, lo
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output busy, stall_req, hi, lo
  );
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit owning HI/LO: fixed-latency MULT/MULTU/DIV/DIVU
// with a busy handshake, single-cycle MTHI/MTLO.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  reset,
  mdu_if.slave  bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  state_e        state_q, state_d;
  op_e           op_q, op_d;
  op_e           op_in;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic          busy_q, busy_d;

  logic [63:0]   mul_a, mul_b, prod;
  logic          div_signed, a_neg, b_neg;
  logic [31:0]   a_mag, b_mag, b_safe, uq, ur, quot, rem;

  assign op_in = op_e'(bus.op);

  // One 64-bit multiplier serves both flavours: sign- or zero-extend first.
  always_comb begin
    mul_a = {{32{a_q[31] & (op_q == OP_MULT)}}, a_q};
    mul_b = {{32{b_q[31] & (op_q == OP_MULT)}}, b_q};
    prod  = mul_a * mul_b;
  end

  // Signed division via magnitudes avoids the INT_MIN / -1 overflow case.
  always_comb begin
    div_signed = (op_q == OP_DIV);
    a_neg      = div_signed & a_q[31];
    b_neg      = div_signed & b_q[31];
    a_mag      = a_neg ? (32'd0 - a_q) : a_q;
    b_mag      = b_neg ? (32'd0 - b_q) : b_q;
    b_safe     = (b_mag == '0) ? 32'd1 : b_mag;
    uq         = a_mag / b_safe;
    ur         = a_mag % b_safe;
    quot       = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
    rem        = a_neg ? (32'd0 - ur) : ur;
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          unique case (op_in)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              op_d    = op_in;
              a_d     = bus.rs_val;
              b_d     = bus.rt_val;
              cnt_d   = ((op_in == OP_MULT) || (op_in == OP_MULTU)) ? CW'(MULT_CYCLES)
                                                                    : CW'(DIV_CYCLES);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            OP_MTHI: hi_d = bus.rs_val;
            OP_MTLO: lo_d = bus.rs_val;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_d  = 1'b0;
          state_d = IDLE;
          unique case (op_q)
            OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
            OP_DIV, OP_DIVU: begin
              if (b_q != '0) begin
                lo_d = quot;
                hi_d = rem;
              end
            end
            default: ;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_NOP;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.stall_req = busy_q | (bus.start && (bus.op >= 3'd1) && (bus.op <= 3'd4));
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: hand-computed HI/LO results, busy duration,
// stall, operand latching, MTHI/MTLO, and reset behaviour.
module tb_mdu;
  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc;

  mdu_if bus();

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request, check stall, accept it, then count busy cycles (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    bus.start  = 1'b1;
    bus.op     = op;
    bus.rs_val = a;
    bus.rt_val = b;
    #1;
    check("stall_req_on_request", {31'd0, bus.stall_req}, {31'd0, (op >= 3'd1 && op <= 3'd4)});
    tick();
    bus.start  = 1'b0;
    bus.rs_val = 32'hDEAD_BEEF;
    bus.rt_val = 32'h0BAD_F00D;
    cycles = 0;
    while (bus.busy && cycles < 100) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.op     = 3'd0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    tick();
    tick();
    check("reset_hi", bus.hi, 32'h0);
    check("reset_lo", bus.lo, 32'h0);
    check("reset_busy", {31'd0, bus.busy}, 32'd0);
    reset = 1'b0;
    tick();

    // MULT -2 * 3
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, cyc);
    check("mult_busy_cycles", cyc, 32'd5);
    check("mult_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_lo", bus.lo, 32'hFFFF_FFFA);

    // MULTU max * max
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    check("multu_busy_cycles", cyc, 32'd5);
    check("multu_hi", bus.hi, 32'hFFFF_FFFE);
    check("multu_lo", bus.lo, 32'h0000_0001);

    // MULT signed max * signed min
    run_op(3'd1, 32'h7FFF_FFFF, 32'h8000_0000, cyc);
    check("mult2_hi", bus.hi, 32'hC000_0000);
    check("mult2_lo", bus.lo, 32'h8000_0000);

    // DIV -7 / 2
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, cyc);
    check("div_busy_cycles", cyc, 32'd10);
    check("div_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_hi", bus.hi, 32'hFFFF_FFFF);

    // DIVU 7 / 0: full latency, HI/LO untouched
    run_op(3'd4, 32'd7, 32'd0, cyc);
    check("divu0_busy_cycles", cyc, 32'd10);
    check("divu0_lo", bus.lo, 32'hFFFF_FFFD);
    check("divu0_hi", bus.hi, 32'hFFFF_FFFF);

    // DIV 7 / -2
    run_op(3'd3, 32'd7, 32'hFFFF_FFFE, cyc);
    check("div_neg_divisor_lo", bus.lo, 32'hFFFF_FFFD);
    check("div_neg_divisor_hi", bus.hi, 32'h0000_0001);

    // DIV INT_MIN / -1
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    check("div_ovf_lo", bus.lo, 32'h8000_0000);
    check("div_ovf_hi", bus.hi, 32'h0);

    // DIVU 0xFFFFFFF9 / 2 (unsigned interpretation)
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2, cyc);
    check("divu_lo", bus.lo, 32'h7FFF_FFFC);
    check("divu_hi", bus.hi, 32'h0000_0001);

    // no-op is ignored and does not stall
    run_op(3'd0, 32'h1111_1111, 32'h2222_2222, cyc);
    check("nop_busy_cycles", cyc, 32'd0);
    check("nop_hi", bus.hi, 32'h0000_0001);

    // MTHI then MTLO on consecutive edges
    bus.start  = 1'b1;
    bus.op     = 3'd5;
    bus.rs_val = 32'h1234_5678;
    #1;
    check("mthi_no_stall", {31'd0, bus.stall_req}, 32'd0);
    tick();
    check("mthi_hi", bus.hi, 32'h1234_5678);
    check("mthi_lo_kept", bus.lo, 32'h7FFF_FFFC);
    check("mthi_busy", {31'd0, bus.busy}, 32'd0);
    bus.op     = 3'd6;
    bus.rs_val = 32'h9ABC_DEF0;
    tick();
    bus.start = 1'b0;
    check("mtlo_lo", bus.lo, 32'h9ABC_DEF0);
    check("mtlo_hi_kept", bus.hi, 32'h1234_5678);
    check("mtlo_busy", {31'd0, bus.busy}, 32'd0);

    // DIVU 100/7 in flight; MTLO held with changed operands until busy falls
    bus.start  = 1'b1;
    bus.op     = 3'd4;
    bus.rs_val = 32'd100;
    bus.rt_val = 32'd7;
    tick();
    bus.op     = 3'd6;
    bus.rs_val = 32'h0000_00AA;
    bus.rt_val = 32'd5;
    #1;
    check("busy_stall_req", {31'd0, bus.stall_req}, 32'd1);
    tick();
    check("mtlo_ignored_busy", bus.lo, 32'h9ABC_DEF0);
    cyc = 1;
    while (bus.busy && cyc < 100) begin
      tick();
      cyc++;
    end
    check("held_div_busy_cycles", cyc, 32'd10);
    check("held_div_lo", bus.lo, 32'd14);
    check("held_div_hi", bus.hi, 32'd2);
    tick();
    bus.start = 1'b0;
    check("mtlo_after_busy_lo", bus.lo, 32'h0000_00AA);
    check("mtlo_after_busy_hi", bus.hi, 32'd2);
    check("mtlo_after_busy_busy", {31'd0, bus.busy}, 32'd0);

    // reset at cnt==3 of a DIV aborts it
    bus.start  = 1'b1;
    bus.op     = 3'd3;
    bus.rs_val = 32'd50;
    bus.rt_val = 32'd5;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("busy_before_abort", {31'd0, bus.busy}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_hi", bus.hi, 32'h0);
    check("abort_lo", bus.lo, 32'h0);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    for (int i = 0; i < 15; i++) tick();
    check("no_late_commit_lo", bus.lo, 32'h0);
    check("no_late_commit_busy", {31'd0, bus.busy}, 32'd0);

    // reset wins over a same-cycle start
    bus.start  = 1'b1;
    bus.op     = 3'd5;
    bus.rs_val = 32'h0000_0055;
    tick();
    check("mthi_pre_reset", bus.hi, 32'h0000_0055);
    reset  = 1'b1;
    bus.op = 3'd1;
    bus.rs_val = 32'd3;
    bus.rt_val = 32'd4;
    tick();
    reset     = 1'b0;
    bus.start = 1'b0;
    check("reset_start_busy", {31'd0, bus.busy}, 32'd0);
    check("reset_start_hi", bus.hi, 32'h0);
    for (int i = 0; i < 7; i++) tick();
    check("reset_start_lo", bus.lo, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
